ternary_layer_sequencer: RTL and testbench
==========================================

Name: ternary_layer_sequencer

Overview:
- Time-multiplexes one ternary perceptron datapath across NUM_NEURONS neurons to evaluate a full binary-output layer.
- Holds a per-neuron packed ternary weight memory, written through a config port.
- Accepts a 4-bit binary activation vector by valid/ready and issues one neuron per cycle to the perceptron. The perceptron is external, with 1-cycle registered output.
- Collects each neuron's sum, thresholds it to one bit, and returns a NUM_NEURONS-bit result vector by valid/ready.

Parameters:
- NUM_NEURONS, 8, neurons per layer (2..16).
- ADDR_W, 3, weight address width; equals clog2(NUM_NEURONS).
- THRESH, 0, signed 8-bit threshold; result bit = (sum > THRESH).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  weight write strobe.
- wr_addr  in  ADDR_W  neuron index to write.
- wr_data  in  8  packed ternary weights; crumb k = bits[2k+1:2k]; 01=+1, 11=-1, 00/10=0.
- in_valid  in  1  activation vector valid.
- in_ready  out  1  sequencer can accept a vector.
- in_data  in  4  binary activations x[3:0].
- pe_weights  out  8  weights to perceptron.
- pe_inputs  out  8  activations to perceptron; x[k] on bit 2k, odd bits 0.
- pe_issue  out  1  high in cycles where pe_weights/pe_inputs carry a live neuron.
- pe_out  in  8  perceptron signed sum; registered, valid one cycle after issue.
- out_valid  out  1  result vector valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  NUM_NEURONS  bit n = neuron n thresholded.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, idx=0, result register=0, weight memory all 0.
  - in_ready=1 after reset deasserts; out_valid=0, out_data=0, pe_issue=0, pe_weights=0, pe_inputs=0, busy=0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - in_ready=1. On in_valid: latch in_data, clear result register, idx=0, go to ISSUE.
  - Weight writes are accepted only in IDLE, including the acceptance edge. A write at the acceptance edge is visible to the layer that starts at that edge.
- ISSUE, one cycle per neuron:
  - pe_issue=1, pe_weights=mem[idx], pe_inputs = latched x mapped to even bits.
  - If idx>0, capture result bit idx-1 from pe_out.
  - If idx==NUM_NEURONS-1, go to DRAIN; otherwise idx+1.
- DRAIN, one cycle:
  - pe_issue=0; capture bit NUM_NEURONS-1 from pe_out; go to DONE.
- DONE:
  - out_valid=1; out_data is the result register, held stable while out_ready=0.
  - On out_ready: out_valid falls next cycle, go to IDLE.
- Latency:
  - Acceptance edge T. Issues occur on T+1..T+N. out_valid rises at T+N+2.
  - Next in_ready is 1 the cycle after the out handshake; no overlap between layers.
- Thresholding: pe_out is interpreted as signed 8-bit. The valid range is -4..+4. Compare signed against THRESH, strictly greater.
- wr_en outside IDLE is ignored and does not change memory. in_valid outside IDLE is not accepted (in_ready=0).
- A wr_addr >= NUM_NEURONS is ignored.
- Reset asserted mid-layer aborts at once. The partial result is discarded and weights are cleared.
- The perceptron's own reset is tied to the system reset at the top level. The sequencer never drives it.

Test Plan:
- Reset values: after reset, memory reads 0; in_ready=1, out_valid=0. Input 4'b1111 → out_data=0x00 (all sums 0, not >0), and out_valid rises exactly N+2 cycles after acceptance.
- Weights and thresholding: write n0=0x55, n1=0xFF, n2=0xAA, n3=0x5D, others 0.
  - in=4'b1111 → out_data=0x09 (n0 sum +4, n1 -4, n2 0, n3 +2).
  - in=4'b0011 → 0x01 (n3 sum 0).
  - in=4'b0101 → 0x09.
- Output backpressure: hold out_ready=0 for 5 cycles in DONE. Required: out_data and out_valid stable, in_ready=0, in_valid ignored, and a wr_en to n0 does not change memory. Releasing out_ready then gives in_ready=1 next cycle.
- Write at acceptance: in the same cycle as in_valid in IDLE, write n0=0xFF. Input 4'b1111 → bit0=0.
- Reset mid-layer: assert reset during ISSUE at idx=3. Required: out_valid=0 and state IDLE immediately; memory reads 0. The next layer with in=4'b1111 gives 0x00.
- Issue timing checker: per layer, pe_issue is high exactly N consecutive cycles; pe_inputs odd bits are always 0; pe_weights equals mem[idx] on each issue.

Source files
------------

// File: rtl/ternary_layer_sequencer.sv
// ternary_layer_sequencer: time-multiplexes one external ternary perceptron across a layer of neurons
// Ports:
//   clk, reset                  clock, async active-high reset
//   wr_en, wr_addr, wr_data     weight memory write port (honoured only in IDLE)
//   in_valid, in_ready, in_data 4-bit binary activation vector handshake
//   pe_weights, pe_inputs       operands to the perceptron for the neuron being issued
//   pe_issue                    high while pe_weights/pe_inputs carry a live neuron
//   pe_out                      perceptron signed sum, one cycle after issue
//   out_valid, out_ready        result vector handshake
//   out_data                    thresholded result, bit n = neuron n
//   busy                        high whenever not IDLE
module ternary_layer_sequencer #(
    parameter int NUM_NEURONS = 8,
    parameter int ADDR_W = 3,
    parameter logic signed [7:0] THRESH = 8'sd0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [7:0]             wr_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_data,
    output logic [7:0]             pe_weights,
    output logic [7:0]             pe_inputs,
    output logic                   pe_issue,
    input  logic [7:0]             pe_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_NEURONS-1:0] out_data,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [7:0] mem [NUM_NEURONS];
    logic [ADDR_W-1:0] idx;
    logic [3:0] x;
    logic [NUM_NEURONS-1:0] result;
    logic signed [7:0] sum;
    logic last, gt;
    assign sum = pe_out;
    assign gt = sum > THRESH;
    assign last = idx == ADDR_W'(NUM_NEURONS - 1);
    assign out_data = result;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        in_ready = 1'b0;
        out_valid = 1'b0;
        pe_issue = 1'b0;
        pe_weights = '0;
        pe_inputs = '0;
        busy = state != IDLE;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                state_n = in_valid ? ISSUE : IDLE;
            end
            ISSUE: begin
                pe_issue = 1'b1;
                pe_weights = mem[idx];
                // activations sit on the even bit of each crumb, odd bits stay 0
                pe_inputs = {1'b0, x[3], 1'b0, x[2], 1'b0, x[1], 1'b0, x[0]};
                state_n = last ? DRAIN : ISSUE;
            end
            DRAIN: state_n = DONE;
            DONE: begin
                out_valid = 1'b1;
                state_n = out_ready ? IDLE : DONE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
            x <= '0;
            result <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) mem[i] <= '0;
        end else begin
            // a write on the acceptance edge lands before the first issue reads mem[0]
            if (state == IDLE && wr_en && int'(wr_addr) < NUM_NEURONS) mem[wr_addr] <= wr_data;
            case (state)
                IDLE: if (in_valid) begin
                    x <= in_data;
                    result <= '0;
                    idx <= '0;
                end
                ISSUE: begin
                    // pe_out now holds the sum of the neuron issued last cycle
                    if (idx != '0) result[idx - 1'b1] <= gt;
                    if (!last) idx <= idx + 1'b1;
                end
                DRAIN: result[NUM_NEURONS-1] <= gt;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ternary_layer_sequencer.sv
// tb_ternary_layer_sequencer: directed bench for ternary_layer_sequencer with a behavioural perceptron
module tb_ternary_layer_sequencer;
    localparam int N = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [3:0] in_data = '0;
    logic [7:0] pe_weights, pe_inputs, pe_out;
    logic pe_issue;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [N-1:0] out_data;
    logic busy;
    logic [7:0] shadow [N];
    int checks = 0;
    int errors = 0;

    ternary_layer_sequencer #(.NUM_NEURONS(N), .ADDR_W(3), .THRESH(8'sd0)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pe_weights(pe_weights), .pe_inputs(pe_inputs), .pe_issue(pe_issue), .pe_out(pe_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] psum(input logic [7:0] w, input logic [7:0] xi);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++)
            if (xi[2*k]) s += (w[2*k +: 2] == 2'b01) ? 1 : (w[2*k +: 2] == 2'b11) ? -1 : 0;
        return 8'(s);
    endfunction

    always @(posedge clk or posedge reset)
        if (reset) pe_out <= '0;
        else pe_out <= psum(pe_weights, pe_inputs);

    function automatic logic [7:0] spread(input logic [3:0] v);
        return {1'b0, v[3], 1'b0, v[2], 1'b0, v[1], 1'b0, v[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d; shadow[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic layer(input logic [3:0] xv, input logic [7:0] exp, input int hold,
                         input bit aw, input logic [7:0] awd);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk("in_ready_before", in_ready, 1);
        in_valid = 1'b1; in_data = xv;
        if (aw) begin wr_en = 1'b1; wr_addr = 3'd0; wr_data = awd; shadow[0] = awd; end
        @(negedge clk);
        in_valid = 1'b0; wr_en = 1'b0; in_data = '0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("issue_%0d", i), pe_issue, 1);
            chk($sformatf("weights_%0d", i), pe_weights, shadow[i]);
            chk($sformatf("inputs_%0d", i), pe_inputs, spread(xv));
            chk($sformatf("early_valid_%0d", i), out_valid, 0);
            chk($sformatf("busy_%0d", i), busy, 1);
            @(negedge clk);
        end
        chk("drain_issue", pe_issue, 0);
        chk("drain_valid", out_valid, 0);
        @(negedge clk);
        chk("out_valid", out_valid, 1);
        chk("out_data", out_data, exp);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_data = 4'hF;
            wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h00;
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, exp);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0; wr_en = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ret_in_ready", in_ready, 1);
        chk("ret_out_valid", out_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) shadow[i] = '0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_pe_issue", pe_issue, 0);
        chk("rst_pe_weights", pe_weights, 0);
        chk("rst_pe_inputs", pe_inputs, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        layer(4'b1111, 8'h00, 0, 0, 8'h00);
        wr(3'd0, 8'h55);
        wr(3'd1, 8'hFF);
        wr(3'd2, 8'hAA);
        wr(3'd3, 8'h5D);
        layer(4'b1111, 8'h09, 0, 0, 8'h00);
        layer(4'b0011, 8'h01, 0, 0, 8'h00);
        layer(4'b0101, 8'h09, 5, 0, 8'h00);
        layer(4'b1111, 8'h08, 0, 1, 8'hFF);
        in_valid = 1'b1; in_data = 4'hF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_issue", pe_issue, 1);
        chk("mid_weights_n3", pe_weights, 8'h5D);
        reset = 1'b1;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_in_ready", in_ready, 1);
        chk("mid_pe_issue", pe_issue, 0);
        chk("mid_out_data", out_data, 0);
        for (int i = 0; i < N; i++) shadow[i] = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        layer(4'b1111, 8'h00, 0, 0, 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
